// File: rtl/click_pkg.sv
// Shared types and constants for the two-input click merge arbiter.
package click_pkg;

   // Handshake phases of the merge controller.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Default payload width of each channel.
   localparam int DATA_W_DEF = 8;

   // Width of the completed-transfer counter.
   localparam int XFER_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, on a tie the
// requester that was not served last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   assign gnt_valid = |req;

   // Select the winning index; value is irrelevant when nobody requests.
   always_comb begin
      gnt_idx = 1'b0;
      case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/click_merge_arb.sv
// Merges two 4-phase requesters onto one 4-phase downstream channel.
// One transfer is in flight at a time; all outputs come straight from flops.
module click_merge_arb
   import click_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            aReq,
   input  logic [DATA_W-1:0]     aData0,
   input  logic [DATA_W-1:0]     aData1,
   output logic [1:0]            aAck,
   output logic                  bReq,
   output logic [DATA_W-1:0]     bData,
   input  logic                  bAck,
   output logic                  bSel,
   output logic [XFER_CNT_W-1:0] xferCount,
   output logic                  protoErr
);

   state_t                r_state;
   logic                  r_last_grant;
   logic [1:0]            r_a_ack;
   logic                  r_b_req;
   logic [DATA_W-1:0]     r_b_data;
   logic                  r_b_sel;
   logic [XFER_CNT_W-1:0] r_xfer_count;
   logic                  r_proto_err;

   state_t                w_state_next;
   logic                  w_last_grant_next;
   logic [1:0]            w_a_ack_next;
   logic                  w_b_req_next;
   logic [DATA_W-1:0]     w_b_data_next;
   logic                  w_b_sel_next;
   logic [XFER_CNT_W-1:0] w_xfer_count_next;
   logic                  w_proto_err_next;

   logic                  w_gnt_valid;
   logic                  w_gnt_idx;

   rr_arb2 u_rr_arb2 (
      .req       (aReq),
      .last      (r_last_grant),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   // Next-state and output decode; bSel doubles as the current grant index.
   always_comb begin
      w_state_next      = r_state;
      w_last_grant_next = r_last_grant;
      w_a_ack_next      = r_a_ack;
      w_b_req_next      = r_b_req;
      w_b_data_next     = r_b_data;
      w_b_sel_next      = r_b_sel;
      w_xfer_count_next = r_xfer_count;
      w_proto_err_next  = r_proto_err;
      case (r_state)
         IDLE: begin
            if (bAck) begin
               w_proto_err_next = 1'b1;
            end
            if (w_gnt_valid) begin
               w_b_data_next = w_gnt_idx ? aData1 : aData0;
               w_b_sel_next  = w_gnt_idx;
               w_b_req_next  = 1'b1;
               w_state_next  = SEND;
            end
         end
         SEND: begin
            // A requester withdrawing mid-transfer is flagged but tolerated.
            if (!aReq[r_b_sel]) begin
               w_proto_err_next = 1'b1;
            end
            if (bAck) begin
               w_b_req_next = 1'b0;
               w_a_ack_next = r_b_sel ? 2'b10 : 2'b01;
               w_state_next = ACK;
            end
         end
         ACK: begin
            // Both sides must have returned to zero before the next transfer.
            if (!aReq[r_b_sel] && !bAck) begin
               w_a_ack_next      = 2'b00;
               w_last_grant_next = r_b_sel;
               w_xfer_count_next = r_xfer_count + 1'b1;
               w_state_next      = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State register; reset abandons any transfer and favours requester 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_a_ack      <= 2'b00;
         r_b_req      <= 1'b0;
         r_b_data     <= '0;
         r_b_sel      <= 1'b0;
         r_xfer_count <= '0;
         r_proto_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_last_grant <= w_last_grant_next;
         r_a_ack      <= w_a_ack_next;
         r_b_req      <= w_b_req_next;
         r_b_data     <= w_b_data_next;
         r_b_sel      <= w_b_sel_next;
         r_xfer_count <= w_xfer_count_next;
         r_proto_err  <= w_proto_err_next;
      end
   end

   assign aAck      = r_a_ack;
   assign bReq      = r_b_req;
   assign bData     = r_b_data;
   assign bSel      = r_b_sel;
   assign xferCount = r_xfer_count;
   assign protoErr  = r_proto_err;

endmodule

// File: tb/tb_click_merge_arb.sv
// Randomized bench for click_merge_arb: requester and downstream agents obey
// the 4-phase protocol (with optional injected violations) and a handshake
// scoreboard predicts every registered output each cycle.
module tb_click_merge_arb;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    aReq = 2'b00;
   logic [DW-1:0] aData0 = '0;
   logic [DW-1:0] aData1 = '0;
   logic          bAck = 1'b0;
   logic [1:0]    aAck;
   logic          bReq;
   logic [DW-1:0] bData;
   logic          bSel;
   logic [7:0]    xferCount;
   logic          protoErr;

   always #5 clk = ~clk;

   click_merge_arb #(.DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .aReq      (aReq),
      .aData0    (aData0),
      .aData1    (aData1),
      .aAck      (aAck),
      .bReq      (bReq),
      .bData     (bData),
      .bAck      (bAck),
      .bSel      (bSel),
      .xferCount (xferCount),
      .protoErr  (protoErr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // stimulus knobs
   int            p_req[2];
   logic [DW-1:0] fix_d[2];
   bit            use_fix;
   bit            ds_rand;
   int            ds_max;
   bit            inj_drop;
   bit            inj_back;

   // agent state
   int rph[2];
   int dph;
   int ds_cnt;
   int ds_tgt;
   bit back_pulse;

   // scoreboard: the open transfer, if any, and the running totals
   bit            m_busy;
   bit            m_acked;
   bit            m_g;
   bit            m_last;
   int            m_count;
   bit            m_err;
   logic [DW-1:0] m_bdata;
   bit            m_bsel;

   // grants observed on the DUT, in order
   int            dut_g[$];
   logic [DW-1:0] dut_d[$];
   bit            prev_breq;

   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) return !last;
      return req[1];
   endfunction

   task automatic agents_reset();
      aReq = 2'b00; aData0 = '0; aData1 = '0; bAck = 1'b0;
      rph[0] = 0; rph[1] = 0; dph = 0; ds_cnt = 0; ds_tgt = -1; back_pulse = 0;
      p_req[0] = 0; p_req[1] = 0; inj_drop = 0; inj_back = 0;
   endtask

   task automatic model_reset();
      m_busy = 0; m_acked = 0; m_g = 0; m_last = 1; m_count = 0; m_err = 0;
      m_bdata = '0; m_bsel = 0;
      dut_g.delete(); dut_d.delete(); prev_breq = 0;
   endtask

   task automatic agents_drive();
      logic [DW-1:0] d;
      for (int i = 0; i < 2; i++) begin
         case (rph[i])
            0: if (int'($urandom_range(99, 0)) < p_req[i]) begin
                  d = use_fix ? fix_d[i] : DW'($urandom);
                  aReq[i] = 1'b1;
                  if (i == 0) aData0 = d; else aData1 = d;
                  rph[i] = 1;
               end
            1: if (aAck[i]) begin
                  aReq[i] = 1'b0; rph[i] = 2;
               end else if (inj_drop && bReq && 32'(bSel) == i) begin
                  aReq[i] = 1'b0; rph[i] = 3; inj_drop = 0;
               end
            2: if (!aAck[i]) rph[i] = 0;
            3: if (aAck[i]) rph[i] = 2;
            default: rph[i] = 0;
         endcase
      end
      if (back_pulse) begin
         bAck = 1'b0; back_pulse = 0;
      end else if (dph == 0) begin
         if (bReq) begin
            if (ds_tgt < 0) ds_tgt = ds_rand ? int'($urandom_range(ds_max, 0)) : ds_max;
            if (ds_cnt >= ds_tgt) begin
               bAck = 1'b1; dph = 1;
            end else begin
               ds_cnt++;
            end
         end else if (inj_back && aAck == 2'b00 && !bAck) begin
            bAck = 1'b1; back_pulse = 1; inj_back = 0;
         end
      end else if (!bReq) begin
         bAck = 1'b0; dph = 0; ds_cnt = 0; ds_tgt = -1;
      end
   endtask

   // Apply the protocol rules to the inputs about to be sampled.
   task automatic model_step();
      if (!m_busy) begin
         if (bAck) m_err = 1;
         if (|aReq) begin
            m_g = rr_pick(aReq, m_last);
            m_busy = 1; m_acked = 0;
            m_bsel = m_g;
            m_bdata = m_g ? aData1 : aData0;
         end
      end else if (!m_acked) begin
         if (!aReq[m_g]) m_err = 1;
         if (bAck) m_acked = 1;
      end else if (!aReq[m_g] && !bAck) begin
         m_busy = 0; m_acked = 0; m_last = m_g;
         m_count = (m_count + 1) % 256;
      end
   endtask

   task automatic compare();
      logic [1:0] exp_ack;
      exp_ack = (m_busy && m_acked) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      check("bReq", 32'(bReq), 32'(m_busy && !m_acked));
      check("aAck", 32'(aAck), 32'(exp_ack));
      check("bData", 32'(bData), 32'(m_bdata));
      check("bSel", 32'(bSel), 32'(m_bsel));
      check("xferCount", 32'(xferCount), 32'(m_count));
      check("protoErr", 32'(protoErr), 32'(m_err));
      check("ack_exclusive", 32'((aAck == 2'b11) || ((|aAck) && bReq)), 32'd0);
      if (bReq && !prev_breq) begin
         dut_g.push_back(int'(bSel));
         dut_d.push_back(bData);
         $display("xfer: grant=%0d data=%02h count=%0d", bSel, bData, xferCount);
      end
      prev_breq = bReq;
   endtask

   task automatic cycle();
      agents_drive();
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      agents_reset();
      model_reset();
      #1;
      check("rst_bReq", 32'(bReq), 32'd0);
      check("rst_aAck", 32'(aAck), 32'd0);
      check("rst_bData", 32'(bData), 32'd0);
      check("rst_bSel", 32'(bSel), 32'd0);
      check("rst_xferCount", 32'(xferCount), 32'd0);
      check("rst_protoErr", 32'(protoErr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      use_fix = 0; ds_rand = 0; ds_max = 0;
      fix_d[0] = '0; fix_d[1] = '0;
      agents_reset();
      model_reset();

      // single transfer from requester 0, bAck two cycles late
      do_reset();
      use_fix = 1; fix_d[0] = 8'hA5; ds_max = 2;
      p_req[0] = 100; cycle(); p_req[0] = 0;
      repeat (12) cycle();
      check("single_bData", 32'(bData), 32'hA5);
      check("single_bSel", 32'(bSel), 32'd0);
      check("single_count", 32'(xferCount), 32'd1);
      check("single_grants", 32'(dut_g.size()), 32'd1);

      // tie: both requesting continuously, alternate from requester 0
      do_reset();
      use_fix = 1; fix_d[0] = 8'h11; fix_d[1] = 8'h22; ds_max = 0;
      p_req[0] = 100; p_req[1] = 100;
      for (int k = 0; k < 200 && dut_g.size() < 4; k++) cycle();
      p_req[0] = 0; p_req[1] = 0;
      check("tie_grants", 32'(dut_g.size() >= 4), 32'd1);
      for (int k = 0; k < 4 && k < dut_g.size(); k++) begin
         check($sformatf("tie_g%0d", k), 32'(dut_g[k]), 32'(k % 2));
         check($sformatf("tie_d%0d", k), 32'(dut_d[k]), (k % 2 == 1) ? 32'h22 : 32'h11);
      end
      repeat (10) cycle();

      // random traffic with pending requests and random downstream delay
      do_reset();
      use_fix = 0; ds_rand = 1; ds_max = 3;
      p_req[0] = 30; p_req[1] = 30;
      repeat (600) cycle();
      p_req[0] = 0; p_req[1] = 0;
      repeat (20) cycle();
      check("rand_progress", 32'(dut_g.size() > 10), 32'd1);
      ds_rand = 0;

      // requester withdraws during SEND: flagged, transfer still completes
      do_reset();
      ds_max = 2;
      p_req[0] = 100; inj_drop = 1; cycle(); p_req[0] = 0;
      repeat (15) cycle();
      check("drop_err", 32'(protoErr), 32'd1);
      check("drop_count", 32'(xferCount), 32'd1);
      repeat (5) cycle();
      check("drop_sticky", 32'(protoErr), 32'd1);

      // bAck pulsed while idle, then a normal transfer
      do_reset();
      inj_back = 1;
      repeat (4) cycle();
      check("idle_err", 32'(protoErr), 32'd1);
      p_req[1] = 100; cycle(); p_req[1] = 0;
      repeat (12) cycle();
      check("idle_err_count", 32'(xferCount), 32'd1);
      check("idle_err_sticky", 32'(protoErr), 32'd1);

      // counter wrap after 256 transfers
      do_reset();
      ds_max = 0;
      p_req[0] = 100;
      for (int k = 0; k < 3000 && m_count != 255; k++) cycle();
      check("wrap_255", 32'(xferCount), 32'd255);
      for (int k = 0; k < 50 && m_count != 0; k++) cycle();
      check("wrap_0", 32'(xferCount), 32'd0);
      p_req[0] = 0;
      repeat (10) cycle();

      // reset asserted mid-transfer clears outputs without a clock edge
      do_reset();
      ds_max = 3;
      p_req[0] = 100; cycle(); p_req[0] = 0;
      repeat (12) cycle();
      p_req[1] = 100; cycle(); p_req[1] = 0;
      for (int k = 0; k < 10 && !bReq; k++) cycle();
      check("mid_inflight", 32'(bReq), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_bReq", 32'(bReq), 32'd0);
      check("mid_aAck", 32'(aAck), 32'd0);
      check("mid_xferCount", 32'(xferCount), 32'd0);
      agents_reset();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      p_req[0] = 100; p_req[1] = 100; cycle();
      p_req[0] = 0; p_req[1] = 0;
      repeat (3) cycle();
      check("post_rst_grant", (dut_g.size() > 0) ? 32'(dut_g[0]) : 32'd99, 32'd0);
      repeat (15) cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
